config_loader: RTL and testbench
================================

# config_loader

Upstream driver of the fabric configuration chain. Accepts the bitstream as parallel words over a valid/ready handshake and serializes it, one bit per cycle, into the daisy-chained tile config shift registers through `config_in`/`config_enable`/`config_nreset`. After a configurable number of bits has been shifted, it stops the chain and raises `fabric_enable` to start user logic.

## Interface
- `WORD_WIDTH`, 8: width of one bitstream word.
- `CHAIN_LENGTH`, 2304: total config bits in the chain, summed over all tiles; ≥ 1.
- `CLEAR_CYCLES`, 2: cycles `config_nreset` is held low before loading; ≥ 1.
- `clock`  in  1  sole clock; all state is on the rising edge.
- `nreset`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request to (re)configure.
- `word_in`  in  WORD_WIDTH  bitstream word.
- `word_valid`  in  1  `word_in` is valid.
- `word_ready`  out  1  loader accepts `word_in` this cycle.
- `config_out`  out  1  serial bit to the `config_in` of the first tile.
- `config_enable`  out  1  chain shift enable, aligned with `config_out`.
- `config_nreset`  out  1  chain clear, active low.
- `busy`  out  1  high in CLEAR or LOAD.
- `done`  out  1  chain fully loaded.
- `fabric_enable`  out  1  enable to user logic; equals `done`.

## Operation
- Reset values: `config_out`=0, `config_enable`=0, `config_nreset`=0, `word_ready`=0, `busy`=0, `done`=0, `fabric_enable`=0. State = IDLE.
- **IDLE**: `config_nreset`=1. `start` moves to CLEAR.
- **CLEAR**: `config_nreset`=0 for exactly CLEAR_CYCLES cycles, then goes to LOAD. The bit counter is zeroed and the holding register is emptied.
- **LOAD**: the holding register shifts out MSB first, one bit per cycle. Each bit drives `config_out` with `config_enable`=1. When the holding register is empty, `config_enable`=0 and `config_out` holds its last value.
  - `word_ready`=1 when the holding register is empty or on its last bit, and more than the in-flight bits of chain remain unshifted. This allows back-to-back words with no bubble.
  - A word is accepted on an edge where `word_valid && word_ready`.
- Bit count: `bits_shifted` counts `config_enable` cycles. Its width is `$clog2(CHAIN_LENGTH+1)`.
- Leaving LOAD: when `bits_shifted` reaches CHAIN_LENGTH, go to DONE.
  - Unshifted bits of the final word are discarded.
  - No further word is accepted.
- **DONE**: `done`=`fabric_enable`=1, `config_nreset`=1, `config_enable`=0. `start` moves to CLEAR, which drops `done` on the same edge.
- Bit placement: the first bit shifted ends in the deepest chain position, i.e. the MSB of the last tile. The host orders the bitstream accordingly.
- `start` in CLEAR or LOAD is ignored.
- Underflow (`word_valid` low while empty): the chain simply does not shift. No timeout and no error.
- Reset mid-operation:
  - All outputs return to their reset values immediately.
  - The partially loaded chain is left as is; the next `start` clears it via CLEAR.

## Timing
- All outputs are registered; no combinational input-to-output path except `word_ready`, which is a function of registered state only.
- Word accepted at edge k: its bits appear on `config_out` with `config_enable`=1 during cycles k+1 … k+WORD_WIDTH. The chain samples each bit at the end of its cycle.
- `start` sampled at edge s:
  - CLEAR occupies cycles s+1 … s+CLEAR_CYCLES.
  - `word_ready` can first be high in cycle s+CLEAR_CYCLES+1.
- Last chain bit driven in cycle t: `done` rises in cycle t+1.
- Minimum total load time: CLEAR_CYCLES + 1 + CHAIN_LENGTH cycles from `start` to `done`, with words always valid.

## Structure
- Package `config_loader_pkg`:
  - state enum `loader_state_t` {IDLE, CLEAR, LOAD, DONE};
  - default parameter constants.
- Sub-module `config_word_serializer`: a WORD_WIDTH piso holding register with load/shift and an `empty`/`last` status. The top holds the FSM, the bit counter and the ready logic.

## Test plan
All scenarios use CHAIN_LENGTH=36, WORD_WIDTH=8, CLEAR_CYCLES=2, with a 36-bit chain model attached.
- Load 5 words 0xA5,0x3C,0xFF,0x00,0x9_ with valid always high.
  - Exactly 36 `config_enable` cycles, no gaps.
  - Chain holds the first 36 stream bits; the low 4 bits of word 5 are dropped.
  - `done` high 2+1+36 cycles after `start`.
- Deassert `word_valid` for 3 cycles between words 2 and 3.
  - `config_enable` low for exactly those cycles.
  - Final chain contents identical to the first scenario.
- Assert `start` during LOAD.
  - Ignored; load completes normally.
  - Then `start` in DONE drops `done` and holds `config_nreset` low for 2 cycles.
- Assert `nreset` low after 17 bits.
  - All outputs go to their reset values asynchronously.
  - Then `start` plus a full reload yields the correct 36 bits.
- CHAIN_LENGTH=8, one word 0x81.
  - `config_out` sequence 1,0,0,0,0,0,0,1.
  - `word_ready` never high again after acceptance.
  - `done` one cycle after the 8th bit.

Source files
------------

// File: rtl/config_loader_pkg.sv
// Shared types and default sizing for the fabric configuration loader.
package config_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD,
        DONE
    } loader_state_t;

    localparam int DEF_WORD_WIDTH   = 8;
    localparam int DEF_CHAIN_LENGTH = 2304;
    localparam int DEF_CLEAR_CYCLES = 2;

endpackage

// File: rtl/config_word_serializer.sv
// PISO holding register: a loaded word leaves MSB first, one bit per advance.
// Latency: loaded MSB visible the cycle after load; no backpressure, the owner gates load/advance.
module config_word_serializer
    import config_loader_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    localparam int CW = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  advance,
    input  logic [WORD_WIDTH-1:0] word,
    output logic                  bit_out,
    output logic                  empty,
    output logic                  last,
    output logic [CW-1:0]         count
);

    logic [WORD_WIDTH-1:0] shreg;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            shreg <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            shreg <= word;
            count <= CW'(WORD_WIDTH);
        end else if (advance && !empty) begin
            // Leaving the last bit in place keeps the serial output steady while starved.
            if (!last) shreg <= shreg << 1;
            count <= count - CW'(1);
        end
    end

    assign bit_out = shreg[WORD_WIDTH-1];
    assign empty   = (count == '0);
    assign last    = (count == CW'(1));

endmodule

// File: rtl/config_loader.sv
// Clears the tile config chain, then serializes bitstream words into it and raises fabric_enable.
// Latency: word bits shift the cycle after acceptance; backpressure via word_ready, underflow just pauses.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int CHAIN_LENGTH = DEF_CHAIN_LENGTH,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_out,
    output logic                  config_enable,
    output logic                  config_nreset,
    output logic                  busy,
    output logic                  done,
    output logic                  fabric_enable
);

    localparam int BW  = $clog2(CHAIN_LENGTH + 1);
    localparam int CCW = $clog2(CLEAR_CYCLES + 1);
    localparam int CW  = $clog2(WORD_WIDTH + 1);
    localparam logic [BW-1:0]  LAST_BIT    = BW'(CHAIN_LENGTH - 1);
    localparam logic [CCW-1:0] CLEAR_LAST  = CCW'(CLEAR_CYCLES - 1);
    localparam logic [31:0]    CHAIN_LEN32 = CHAIN_LENGTH;

    loader_state_t  state;
    logic [BW-1:0]  bits_shifted;
    logic [CCW-1:0] clear_cnt;
    logic [CW-1:0]  ser_count;
    logic           ser_empty;
    logic           ser_last;
    logic           ser_clear;
    logic           accept;
    logic           finishing;
    logic [31:0]    committed_end;

    // Shifted bits plus those still held must stay short of the chain before taking another word.
    assign committed_end = 32'(bits_shifted) + 32'(ser_count);
    assign word_ready    = (state == LOAD) && (ser_empty || ser_last) && (committed_end < CHAIN_LEN32);
    assign accept        = word_valid && word_ready;
    assign finishing     = (state == LOAD) && config_enable && (bits_shifted == LAST_BIT);
    assign ser_clear     = (state == CLEAR) || finishing;
    assign fabric_enable = done;

    config_word_serializer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_serializer (
        .clock   (clock),
        .nreset  (nreset),
        .clear   (ser_clear),
        .load    (accept),
        .advance (state == LOAD),
        .word    (word_in),
        .bit_out (config_out),
        .empty   (ser_empty),
        .last    (ser_last),
        .count   (ser_count)
    );

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state         <= IDLE;
            bits_shifted  <= '0;
            clear_cnt     <= '0;
            config_enable <= 1'b0;
            config_nreset <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    config_nreset <= 1'b1;
                    if (start) begin
                        state         <= CLEAR;
                        config_nreset <= 1'b0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        clear_cnt     <= '0;
                    end
                end
                CLEAR: begin
                    bits_shifted <= '0;
                    if (clear_cnt == CLEAR_LAST) begin
                        state         <= LOAD;
                        config_nreset <= 1'b1;
                    end else begin
                        clear_cnt <= clear_cnt + CCW'(1);
                    end
                end
                LOAD: begin
                    if (config_enable) bits_shifted <= bits_shifted + BW'(1);
                    if (finishing) begin
                        state         <= DONE;
                        config_enable <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end else begin
                        config_enable <= accept || (!ser_empty && !ser_last);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a 36-bit chain instance with a stream model, plus an 8-bit chain instance.
module tb_config_loader;

    localparam int WW   = 8;
    localparam int CL_A = 36;
    localparam int CL_B = 8;
    localparam int CC   = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic nreset;
    logic a_start, a_word_valid, a_word_ready, a_config_out, a_config_enable;
    logic a_config_nreset, a_busy, a_done, a_fabric_enable;
    logic [WW-1:0] a_word_in;
    logic b_start, b_word_valid, b_word_ready, b_config_out, b_config_enable;
    logic b_config_nreset, b_busy, b_done, b_fabric_enable;
    logic [WW-1:0] b_word_in;

    config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL_A), .CLEAR_CYCLES(CC)) dut_a (
        .clock(clock), .nreset(nreset), .start(a_start), .word_in(a_word_in),
        .word_valid(a_word_valid), .word_ready(a_word_ready), .config_out(a_config_out),
        .config_enable(a_config_enable), .config_nreset(a_config_nreset), .busy(a_busy),
        .done(a_done), .fabric_enable(a_fabric_enable));

    config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL_B), .CLEAR_CYCLES(CC)) dut_b (
        .clock(clock), .nreset(nreset), .start(b_start), .word_in(b_word_in),
        .word_valid(b_word_valid), .word_ready(b_word_ready), .config_out(b_config_out),
        .config_enable(b_config_enable), .config_nreset(b_config_nreset), .busy(b_busy),
        .done(b_done), .fabric_enable(b_fabric_enable));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Stream model: bits of accepted words in shift order, plus shifted-bit bookkeeping.
    bit exp_q[$];
    int ens, committed, gaps;
    bit seen_en, prev_en, prev_done, model_rdy, abort;
    logic [CL_A-1:0] chain;
    logic [WW-1:0] words [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h96};

    function automatic void model_clear();
        exp_q.delete();
        ens       = 0;
        committed = 0;
        gaps      = 0;
        seen_en   = 0;
    endfunction

    // Tile chain attached to instance A: first bit shifted ends in the top position.
    always @(posedge clock) begin
        if (!a_config_nreset) chain <= '0;
        else if (a_config_enable) chain <= {chain[CL_A-2:0], a_config_out};
    end

    always @(negedge clock) begin
        if (nreset) begin
            model_rdy = a_busy && a_config_nreset && (exp_q.size() <= 1)
                        && (ens + exp_q.size() < CL_A);
            check("word_ready", a_word_ready, model_rdy);
            check("fabric_enable", a_fabric_enable, a_done);
            if (a_config_enable) begin
                check("bit_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("config_out", a_config_out, exp_q.pop_front());
                ens++;
                seen_en = 1;
            end else if (seen_en && a_busy && a_config_nreset) begin
                gaps++;
            end
            if (a_done && !prev_done) begin
                check("done_after_last_bit", prev_en, 1'b1);
                check("bits_at_done", ens, CL_A);
            end
            if (a_word_valid && a_word_ready) begin
                check("accept_allowed", committed < CL_A, 1'b1);
                for (int b = WW - 1; b >= 0; b--) exp_q.push_back(a_word_in[b]);
                committed += WW;
            end
            prev_en   = a_config_enable;
            prev_done = a_done;
        end
    end

    task automatic feed_a(input int gap_at, input int gap_len);
        int t;
        for (int i = 0; i < 5; i++) begin
            if (i == gap_at) begin
                int g = 0;
                a_word_valid = 0;
                t = 0;
                while (g < gap_len && t < 300) begin
                    @(negedge clock);
                    t++;
                    if (abort) return;
                    if (a_word_ready) g++;
                end
                @(posedge clock);
                #1;
            end
            a_word_in    = words[i];
            a_word_valid = 1;
            t = 0;
            do begin
                @(negedge clock);
                if (abort) begin
                    a_word_valid = 0;
                    return;
                end
                t++;
            end while (!a_word_ready && t < 300);
            if (!a_word_ready) begin
                check("word_accept", a_word_ready, 1'b1);
                a_word_valid = 0;
                return;
            end
            @(posedge clock);
            #1;
        end
        a_word_valid = 0;
    endtask

    task automatic run_load(input int gap_at, input int gap_len, input bit poke);
        int lat;
        model_clear();
        @(posedge clock);
        #1 a_start = 1;
        @(posedge clock);
        #1 a_start = 0;
        fork
            feed_a(gap_at, gap_len);
            begin
                lat = 0;
                while (!a_done && lat < 300) begin
                    @(posedge clock);
                    lat++;
                    #1;
                end
            end
            begin
                if (poke) begin
                    repeat (15) @(posedge clock);
                    #1 a_start = 1;
                    @(posedge clock);
                    #1 a_start = 0;
                end
            end
        join
        repeat (4) @(negedge clock);
        check("start_to_done", lat, CC + 1 + CL_A + gap_len);
        check("enable_cycles", ens, CL_A);
        check("enable_gap_cycles", gaps, gap_len);
        check("chain_contents", chain, 36'hA53CFF009);
    endtask

    task automatic run_b();
        int t, seq_n, rdy_n, last_en, done_at;
        logic [7:0] seq;
        seq = '0; seq_n = 0; rdy_n = 0; last_en = -1; done_at = -1; t = 0;
        @(posedge clock);
        #1 b_start = 1;
        @(posedge clock);
        #1 b_start = 0;
        b_word_in    = 8'h81;
        b_word_valid = 1;
        do begin
            @(negedge clock);
            t++;
        end while (!b_word_ready && t < 50);
        check("b_first_ready", b_word_ready, 1'b1);
        @(posedge clock);
        #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (b_config_enable) begin
                seq = {seq[6:0], b_config_out};
                seq_n++;
                last_en = i;
            end
            if (b_word_ready) rdy_n++;
            if (b_done && done_at < 0) done_at = i;
        end
        b_word_valid = 0;
        check("b_bit_sequence", seq, 8'h81);
        check("b_enable_cycles", seq_n, CL_B);
        check("b_ready_after_accept", rdy_n, 0);
        check("b_done_cycle", done_at, last_en + 1);
        check("b_fabric_enable", b_fabric_enable, 1'b1);
    endtask

    initial begin
        int n, t;
        nreset = 0; abort = 0;
        a_start = 0; a_word_valid = 0; a_word_in = '0;
        b_start = 0; b_word_valid = 0; b_word_in = '0;
        model_clear();
        #3;
        check("a_reset_outputs", {a_config_out, a_config_enable, a_config_nreset, a_word_ready,
                                  a_busy, a_done, a_fabric_enable}, 7'b0);
        check("b_reset_outputs", {b_config_out, b_config_enable, b_config_nreset, b_word_ready,
                                  b_busy, b_done, b_fabric_enable}, 7'b0);
        @(posedge clock);
        #1 nreset = 1;
        repeat (2) @(negedge clock);
        check("idle_outputs", {a_config_nreset, a_busy, a_done}, 3'b100);

        run_load(-1, 0, 0);
        run_load(2, 3, 0);
        run_load(-1, 0, 1);

        // Restart from DONE: done drops on the start edge, then the chain is cleared.
        model_clear();
        @(posedge clock);
        #1 a_start = 1;
        @(posedge clock);
        #1 a_start = 0;
        check("restart_from_done", {a_done, a_fabric_enable, a_config_nreset, a_busy}, 4'b0001);
        n = 0;
        repeat (6) begin
            @(negedge clock);
            if (!a_config_nreset) n++;
        end
        check("clear_cycles", n, CC);

        // Reset part-way through a load, then reload from scratch.
        model_clear();
        fork
            feed_a(-1, 0);
        join_none
        t = 0;
        while (ens < 17 && t < 300) begin
            @(negedge clock);
            t++;
        end
        #2 nreset = 0;
        #1;
        check("midload_reset_outputs", {a_config_out, a_config_enable, a_config_nreset, a_word_ready,
                                        a_busy, a_done, a_fabric_enable}, 7'b0);
        abort = 1;
        repeat (3) @(negedge clock);
        abort = 0;
        a_word_valid = 0;
        model_clear();
        @(posedge clock);
        #1 nreset = 1;
        run_load(-1, 0, 0);

        run_b();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule
